// File: rtl/attn_out_collector_if.sv
// rtl/attn_out_collector_if.sv - beat stream, SRAM pins and readback port of the attention output collector
interface attn_out_if #(
  parameter int ROW_W   = 2,
  parameter int GROUP_W = 5,
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 7
);
  logic              in_valid;
  logic [ROW_W-1:0]  in_row;
  logic [GROUP_W-1:0] in_group;
  logic [DATA_W-1:0] in_data;

  logic              MEM_CEB;
  logic              MEM_WEN;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_DIN;
  logic [DATA_W-1:0] MEM_DOUT;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output in_valid, in_row, in_group, in_data, MEM_DOUT, rd_req, rd_addr,
    input  MEM_CEB, MEM_WEN, MEM_ADDR, MEM_DIN, rd_valid, rd_data
  );

  modport slave (
    input  in_valid, in_row, in_group, in_data, MEM_DOUT, rd_req, rd_addr,
    output MEM_CEB, MEM_WEN, MEM_ADDR, MEM_DIN, rd_valid, rd_data
  );
endinterface

// File: rtl/attn_out_collector.sv
// rtl/attn_out_collector.sv - collects attention output beats into a result SRAM with scoreboard and readback
module attn_out_collector #(
  parameter int ROWS     = 4,
  parameter int GROUPS   = 32,
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 7,
  parameter int READ_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            attn_done,
  attn_out_if.slave       bus,
  output logic            busy,
  output logic            collected,
  output logic [ADDR_W:0] count,
  output logic            err_dup,
  output logic            err_missing
);

  localparam int TOTAL = ROWS * GROUPS;
  localparam logic [ADDR_W:0] TOTAL_C = (ADDR_W + 1)'(TOTAL);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t              state;
  logic [TOTAL-1:0]    sb;
  logic [READ_LAT:0]   rd_pipe;
  logic [DATA_W-1:0]   rd_hold;
  logic [ADDR_W-1:0]   beat_addr;
  logic                accept;
  logic                is_new;
  logic                rd_issue;
  logic [ADDR_W:0]     count_next;

  assign beat_addr = {bus.in_row, bus.in_group};
  assign busy      = (state == COLLECT);

  // The read pipe's last stage lines up with valid MEM_DOUT; rd_data falls back to the last captured word.
  assign bus.rd_valid = rd_pipe[READ_LAT];
  assign bus.rd_data  = rd_pipe[READ_LAT] ? bus.MEM_DOUT : rd_hold;

  // Beat acceptance and scoreboard lookup; a beat in the start cycle belongs to no run and is dropped.
  always_comb begin
    accept     = 1'b0;
    is_new     = 1'b0;
    rd_issue   = 1'b0;
    count_next = count;
    if (state == COLLECT && bus.in_valid && !start) begin
      accept = 1'b1;
      is_new = !sb[beat_addr];
    end
    if (state == DONE && bus.rd_req && !start) begin
      rd_issue = 1'b1;
    end
    count_next = count + {{ADDR_W{1'b0}}, is_new};
  end

  // FSM, scoreboard, status flags, registered SRAM pins and readback tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sb           <= '0;
      count        <= '0;
      collected    <= 1'b0;
      err_dup      <= 1'b0;
      err_missing  <= 1'b0;
      rd_pipe      <= '0;
      rd_hold      <= '0;
      bus.MEM_CEB  <= 1'b1;
      bus.MEM_WEN  <= 1'b1;
      bus.MEM_ADDR <= '0;
      bus.MEM_DIN  <= '0;
    end else begin
      if (rd_pipe[READ_LAT]) begin
        rd_hold <= bus.MEM_DOUT;
      end
      // start drops any reads still in flight so the new run never sees stale rd_valid.
      if (start) begin
        rd_pipe <= '0;
      end else begin
        rd_pipe <= {rd_pipe[READ_LAT-1:0], rd_issue};
      end

      if (accept) begin
        bus.MEM_CEB  <= 1'b0;
        bus.MEM_WEN  <= 1'b0;
        bus.MEM_ADDR <= beat_addr;
        bus.MEM_DIN  <= bus.in_data;
      end else if (rd_issue) begin
        bus.MEM_CEB  <= 1'b0;
        bus.MEM_WEN  <= 1'b1;
        bus.MEM_ADDR <= bus.rd_addr;
      end else begin
        bus.MEM_CEB  <= 1'b1;
        bus.MEM_WEN  <= 1'b1;
      end

      if (start) begin
        state       <= COLLECT;
        sb          <= '0;
        count       <= '0;
        collected   <= 1'b0;
        err_dup     <= 1'b0;
        err_missing <= 1'b0;
      end else if (state == COLLECT) begin
        if (accept) begin
          sb[beat_addr] <= 1'b1;
          count         <= count_next;
          if (!is_new) begin
            err_dup <= 1'b1;
          end
        end
        // A final beat wins over a simultaneous attn_done, so that run is complete, not missing.
        if (accept && count_next == TOTAL_C) begin
          state     <= DONE;
          collected <= 1'b1;
        end else if (attn_done) begin
          state       <= DONE;
          err_missing <= 1'b1;
        end
      end
    end
  end

endmodule
